prog_loader: RTL and testbench

Byte-stream program loader that writes the processor's instruction memory, the write-side counterpart of the instruction fetch path. It accepts framed bytes from the serial receiver over a valid/ready handshake, writes each payload byte to consecutive instruction-memory addresses from 0, and holds the core stopped while a load is in progress. It reports completion or a classified error.

---
 rtl/stack_pkg.sv | 21 ++
 rtl/prog_loader_timeout.sv | 44 ++++
 rtl/prog_loader.sv | 211 +++++++++++++++++++++
 tb/tb_prog_loader.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared types and constants for the program loader
// Purpose: loader state encoding, error codes and the default frame marker.
// Ports: none (package).
package stack_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    REPORT
  } loader_state_e;

  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/prog_loader_timeout.sv
// rtl/prog_loader_timeout.sv - inter-byte idle timer for the program loader
// Purpose: down-counter restarted on every accepted byte; flags expiry once
//          CYCLES clocks pass without a restart while a frame is in progress.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   load_i      - restart the count (byte accepted)
//   en_i        - count only while a frame is in progress
//   expired_o   - CYCLES clocks have passed since the last restart
module prog_loader_timeout #(
  parameter int unsigned CYCLES = 1_600_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  // Loading CYCLES-1 makes expiry fire on exactly the CYCLES-th idle edge.
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && !load_i && (cnt_q == '0);

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream loader for instruction memory
// Purpose: parses SYNC, LEN_HI, LEN_LO, payload[, CSUM] frames, writes the
//          payload from address 0, holds the core during loads and reports
//          success or a classified error.
// Optional feature: define PROG_LOADER_CHECKSUM_EN to expect and check a
//          trailing modulo-256 payload sum byte.
// Ports:
//   clk, rst_n                    - clock, asynchronous active-low reset
//   in_data, in_valid, in_ready   - byte input handshake
//   mem_we, mem_addr, mem_wdata   - registered instruction-memory write port
//   core_hold                     - core must stay stopped while high
//   load_done, load_err, err_code - one-cycle completion/error report
module prog_loader
  import stack_pkg::*;
#(
  parameter int unsigned ADDR_W         = 8,
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 1_600_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [1:0]        err_code
);

  // 17 bits so that 2^16 itself is representable when ADDR_W = 16.
  localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

  loader_state_e     state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              core_hold_q, core_hold_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;
  logic [1:0]        err_code_q, err_code_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  logic        accept;
  logic        in_frame;
  logic        timed_out;
  logic [15:0] len_rx;
  logic [15:0] cnt_next;

  assign in_ready = (state_q != REPORT);
  assign accept   = in_valid && in_ready;
  assign in_frame = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                    (state_q == DATA)   || (state_q == CSUM);
  assign len_rx   = {len_q[15:8], in_data};
  assign cnt_next = cnt_q + 16'd1;

  prog_loader_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (accept),
    .en_i      (in_frame),
    .expired_o (timed_out)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    core_hold_d = core_hold_q;
    load_done_d = 1'b0;
    load_err_d  = 1'b0;
    err_code_d  = err_code_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept && (in_data == SYNC_BYTE)) begin
          state_d     = LEN_HI;
          core_hold_d = 1'b1;
          cnt_d       = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d       = '0;
`endif
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_d   = {in_data, 8'h00};
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_d = len_rx;
          if ({1'b0, len_rx} > MAX_LEN) begin
            state_d    = REPORT;
            load_err_d = 1'b1;
            err_code_d = ERR_LEN;
          end else if (len_rx == '0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_d     = CSUM;
`else
            state_d     = REPORT;
            load_done_d = 1'b1;
`endif
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt_q[ADDR_W-1:0];
          mem_wdata_d = in_data;
          cnt_d       = cnt_next;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d       = sum_q + in_data;
          if (cnt_next == len_q) state_d = CSUM;
`else
          if (cnt_next == len_q) begin
            state_d     = REPORT;
            load_done_d = 1'b1;
          end
`endif
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept) begin
          state_d = REPORT;
          if (in_data == sum_q) begin
            load_done_d = 1'b1;
          end else begin
            load_err_d = 1'b1;
            err_code_d = ERR_CSUM;
          end
        end
      end
`endif
      REPORT: begin
        state_d = IDLE;
        // Only a successful frame releases the core; after an error the
        // memory image may be partial, so the hold persists.
        if (load_done_q) core_hold_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (timed_out) begin
      state_d    = REPORT;
      load_err_d = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      core_hold_q <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      err_code_q  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      core_hold_q <= core_hold_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
      err_code_q  <= err_code_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign core_hold = core_hold_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

  localparam int unsigned T_OUT = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       core_hold;
  logic       load_done;
  logic       load_err;
  logic [1:0] err_code;

  prog_loader #(
    .ADDR_W         (8),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (T_OUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_hold (core_hold),
    .load_done (load_done),
    .load_err  (load_err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Passive monitor: cumulative event counts and a log of every write.
  int          done_tot = 0;
  int          err_tot = 0;
  logic [15:0] wr_log[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we)    wr_log.push_back({mem_addr, mem_wdata});
      if (load_done) done_tot++;
      if (load_err)  err_tot++;
    end
  end

  int d0, e0, w0;

  task automatic mark();
    d0 = done_tot;
    e0 = err_tot;
    w0 = wr_log.size();
  endtask

  // Present a byte and return 1 time unit after the edge that takes it.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_data(input string tag, input logic [7:0] b, input logic [7:0] addr);
    send(b);
    chk({tag, "_we"}, {31'd0, mem_we}, 32'd1);
    chk({tag, "_addr"}, {24'd0, mem_addr}, {24'd0, addr});
    chk({tag, "_wdata"}, {24'd0, mem_wdata}, {24'd0, b});
  endtask

  // Sends the checksum byte when that feature is built in, then checks that
  // load_done is high right after the frame's last byte.
  task automatic finish_frame(input string tag, input logic [7:0] csum);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(csum);
`else
    csum = csum;
`endif
    chk({tag, "_done_pulse"}, {31'd0, load_done}, 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    repeat (3) @(posedge clk);
    #1;
    // Reset values
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("rst_core_hold", {31'd0, core_hold}, 32'd0);
    chk("rst_done_err", {30'd0, load_done, load_err}, 32'd0);
    chk("rst_err_code", {30'd0, err_code}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // A5 00 03 10 2A 30 [6A]
    mark();
    send(8'hA5);
    chk("t1_hold_set", {31'd0, core_hold}, 32'd1);
    send(8'h00);
    send(8'h03);
    send_data("t1_b0", 8'h10, 8'd0);
    send_data("t1_b1", 8'h2A, 8'd1);
    send_data("t1_b2", 8'h30, 8'd2);
    finish_frame("t1", 8'h6A);
    chk("t1_report_ready", {31'd0, in_ready}, 32'd0);
    idle(3);
    chk("t1_done_cnt", done_tot - d0, 32'd1);
    chk("t1_err_cnt", err_tot - e0, 32'd0);
    chk("t1_hold_clr", {31'd0, core_hold}, 32'd0);
    chk("t1_ready_back", {31'd0, in_ready}, 32'd1);

    // 00 FF dropped, then A5 00 01 07 [07]
    mark();
    send(8'h00);
    send(8'hFF);
    chk("t2_no_hold", {31'd0, core_hold}, 32'd0);
    send(8'hA5);
    send(8'h00);
    send(8'h01);
    send_data("t2_b0", 8'h07, 8'd0);
    finish_frame("t2", 8'h07);
    idle(3);
    chk("t2_wr_cnt", wr_log.size() - w0, 32'd1);
    chk("t2_done_cnt", done_tot - d0, 32'd1);

`ifdef PROG_LOADER_CHECKSUM_EN
    // A5 00 02 01 02, bad checksum 00
    mark();
    send(8'hA5);
    send(8'h00);
    send(8'h02);
    send_data("t3_b0", 8'h01, 8'd0);
    send_data("t3_b1", 8'h02, 8'd1);
    send(8'h00);
    chk("t3_err_pulse", {31'd0, load_err}, 32'd1);
    chk("t3_err_code", {30'd0, err_code}, 32'd2);
    idle(3);
    chk("t3_hold_kept", {31'd0, core_hold}, 32'd1);
    chk("t3_done_cnt", done_tot - d0, 32'd0);
`endif

    // LEN 257 overflows an 8-bit address space
    mark();
    send(8'hA5);
    send(8'h01);
    send(8'h01);
    chk("t4_err_pulse", {31'd0, load_err}, 32'd1);
    chk("t4_err_code", {30'd0, err_code}, 32'd1);
    idle(3);
    chk("t4_no_write", wr_log.size() - w0, 32'd0);
    chk("t4_hold_kept", {31'd0, core_hold}, 32'd1);
    chk("t4_code_holds", {30'd0, err_code}, 32'd1);

    // A5 00 04 11 then silence: error exactly T_OUT edges after the 11
    mark();
    send(8'hA5);
    send(8'h00);
    send(8'h04);
    send_data("t5_b0", 8'h11, 8'd0);
    in_valid = 1'b0;
    repeat (T_OUT - 1) @(posedge clk);
    #1;
    chk("t5_not_yet", {31'd0, load_err}, 32'd0);
    @(posedge clk);
    #1;
    chk("t5_err_pulse", {31'd0, load_err}, 32'd1);
    chk("t5_err_code", {30'd0, err_code}, 32'd3);
    idle(3);
    chk("t5_err_cnt", err_tot - e0, 32'd1);
    chk("t5_hold_kept", {31'd0, core_hold}, 32'd1);

    // Good frame after errors: A5 00 01 FF [FF] releases the core
    mark();
    send(8'hA5);
    send(8'h00);
    send(8'h01);
    send_data("t6_b0", 8'hFF, 8'd0);
    finish_frame("t6", 8'hFF);
    idle(3);
    chk("t6_hold_clr", {31'd0, core_hold}, 32'd0);
    chk("t6_err_cnt", err_tot - e0, 32'd0);

    // LEN 0: no writes, success
    mark();
    send(8'hA5);
    send(8'h00);
    send(8'h00);
    finish_frame("t7", 8'h00);
    idle(3);
    chk("t7_no_write", wr_log.size() - w0, 32'd0);
    chk("t7_done_cnt", done_tot - d0, 32'd1);

    // LEN 256: full space, last address FF, no wrap; sum of 0..255 = 80
    mark();
    bad = 0;
    send(8'hA5);
    send(8'h01);
    send(8'h00);
    for (int i = 0; i < 256; i++) begin
      send(i[7:0]);
      if (!(mem_we === 1'b1 && mem_addr === i[7:0] && mem_wdata === i[7:0])) bad++;
    end
    finish_frame("t8", 8'h80);
    chk("t8_last_addr", {24'd0, mem_addr}, 32'hFF);
    idle(3);
    chk("t8_bad_writes", bad, 32'd0);
    chk("t8_wr_cnt", wr_log.size() - w0, 32'd256);
    chk("t8_err_cnt", err_tot - e0, 32'd0);

    // Reset mid-frame
    send(8'hA5);
    send(8'h00);
    send(8'h05);
    send(8'h01);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t9_hold_clr", {31'd0, core_hold}, 32'd0);
    chk("t9_ready", {31'd0, in_ready}, 32'd1);
    chk("t9_we_clr", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    mark();
    send(8'hA5);
    send(8'h00);
    send(8'h01);
    send_data("t9_b0", 8'h5C, 8'd0);
    finish_frame("t9", 8'h5C);
    idle(3);
    chk("t9_done_cnt", done_tot - d0, 32'd1);
    chk("t9_hold_after", {31'd0, core_hold}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
